// File: rtl/exec_ctrl_pkg.sv
// Shared types and constants for the execution step controller.
package exec_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } exec_state_e;

  localparam int               CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_SAT = 16'hFFFF;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchroniser for an asynchronous board input, with a registered
// rising-edge pulse that is one cycle wide regardless of how long the input is held.
module btn_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic rise_q, rise_d;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise_d  = sync2_q & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      rise_q  <= rise_d;
    end
  end

  assign level = sync2_q;
  assign rise  = rise_q;

endmodule

// File: rtl/exec_step_controller.sv
// Execution sequencer for the single-cycle core: single-step, free-run, halt, init.
// Breakpoint support is built only when EXEC_BREAKPOINT_EN is defined.
//
// state | meaning
// INIT  | core_reset held for RST_CYCLES cycles, counters cleared
// IDLE  | waiting; step edge issues one strobe, run edge enters RUN
// RUN   | strobe every RUN_DIV cycles until run_sw low, breakpoint or end
// HALT  | pc past MAX_PC; step with run_sw low re-initialises
module exec_step_controller
  import exec_ctrl_pkg::*;
#(
  parameter int RUN_DIV    = 25_000_000,
  parameter int MAX_PC     = 124,
  parameter int RST_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_btn,
  input  logic             run_sw,
  input  logic [31:0]      pc,
  input  logic [31:0]      bp_addr,
  input  logic             bp_valid,
  output logic             core_en,
  output logic             core_reset,
  output logic [1:0]       state,
  output logic             halted,
  output logic             bp_hit,
  output logic [CNT_W-1:0] instr_count
);

  localparam int               DIV_W    = $clog2(RUN_DIV);
  localparam int               RST_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_TERM = DIV_W'(RUN_DIV - 1);
  localparam logic [RST_W-1:0] RST_TERM = RST_W'(RST_CYCLES - 1);
  localparam logic [31:0]      MAX_PC_W = 32'(MAX_PC);

  exec_state_e      state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [RST_W-1:0] init_cnt_q, init_cnt_d;
  logic             core_en_q, core_en_d;
  logic             core_reset_q, core_reset_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic step_rise, run_rise, run_level;
  logic unused_step_level;
  logic past_end, bp_stop, run_entry, bp_taken;

  btn_edge_sync u_step_sync (
    .clk   (clk),
    .reset (reset),
    .din   (step_btn),
    .level (unused_step_level),
    .rise  (step_rise)
  );

  btn_edge_sync u_run_sync (
    .clk   (clk),
    .reset (reset),
    .din   (run_sw),
    .level (run_level),
    .rise  (run_rise)
  );

  // pc is only trusted while no strobe is in flight; it moves on the strobe edge.
  assign past_end = !core_en_q && (pc > MAX_PC_W);

`ifdef EXEC_BREAKPOINT_EN
  logic bp_skip_q, bp_skip_d;
  logic bp_hit_q, bp_hit_d;

  // bp_skip lets a resumed run execute the instruction it stopped on.
  assign bp_stop = bp_valid && (pc == bp_addr) && !bp_skip_q;

  always_comb begin
    bp_skip_d = bp_skip_q;
    bp_hit_d  = bp_hit_q;
    if (run_entry) begin
      bp_skip_d = 1'b1;
      bp_hit_d  = 1'b0;
    end else if (core_en_d) begin
      bp_skip_d = 1'b0;
    end
    if (bp_taken) bp_hit_d = 1'b1;
    if (state_d == ST_INIT) bp_hit_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bp_skip_q <= 1'b0;
      bp_hit_q  <= 1'b0;
    end else begin
      bp_skip_q <= bp_skip_d;
      bp_hit_q  <= bp_hit_d;
    end
  end

  assign bp_hit = bp_hit_q;
`else
  logic unused_bp;
  assign unused_bp = ^{bp_addr, bp_valid, run_entry, bp_taken};
  assign bp_stop   = 1'b0;
  assign bp_hit    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    init_cnt_d = init_cnt_q;
    core_en_d  = 1'b0;
    run_entry  = 1'b0;
    bp_taken   = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == RST_TERM) state_d = ST_IDLE;
        else                        init_cnt_d = init_cnt_q + RST_W'(1);
      end
      ST_IDLE: begin
        if (past_end) begin
          state_d = ST_HALT;
        end else if (run_rise) begin
          state_d   = ST_RUN;
          div_d     = '0;
          run_entry = 1'b1;
        end else if (step_rise) begin
          core_en_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (past_end) begin
          state_d = ST_HALT;
        end else if (!run_level) begin
          state_d = ST_IDLE;
        end else if (div_q == DIV_TERM) begin
          div_d = '0;
          if (bp_stop) begin
            state_d  = ST_IDLE;
            bp_taken = 1'b1;
          end else begin
            core_en_d = 1'b1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_HALT: begin
        if (step_rise && !run_level) begin
          state_d    = ST_INIT;
          init_cnt_d = '0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    core_reset_d = (state_d == ST_INIT);
    halted_d     = (state_d == ST_HALT);
    count_d      = count_q;
    if (state_d == ST_INIT) count_d = '0;
    else if (core_en_d)     count_d = sat_inc(count_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_INIT;
      div_q        <= '0;
      init_cnt_q   <= '0;
      core_en_q    <= 1'b0;
      core_reset_q <= 1'b1;
      halted_q     <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      init_cnt_q   <= init_cnt_d;
      core_en_q    <= core_en_d;
      core_reset_q <= core_reset_d;
      halted_q     <= halted_d;
      count_q      <= count_d;
    end
  end

  assign core_en     = core_en_q;
  assign core_reset  = core_reset_q;
  assign state       = state_q;
  assign halted      = halted_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_exec_step_controller.sv
// Directed bench for exec_step_controller with a strobe scoreboard and a simple PC model.
module tb_exec_step_controller;
  import exec_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset, step_btn, run_sw, bp_valid;
  logic [31:0] pc, bp_addr;
  logic        core_en, core_reset, halted, bp_hit;
  logic [1:0]  state;
  logic [15:0] instr_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
  } exp_t;
  exp_t exp_q[$];

  exec_step_controller #(.RUN_DIV(5), .MAX_PC(124), .RST_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .step_btn    (step_btn),
    .run_sw      (run_sw),
    .pc          (pc),
    .bp_addr     (bp_addr),
    .bp_valid    (bp_valid),
    .core_en     (core_en),
    .core_reset  (core_reset),
    .state       (state),
    .halted      (halted),
    .bp_hit      (bp_hit),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int c, input logic [31:0] p);
    exp_t e;
    e.cyc = c;
    e.pc  = p;
    exp_q.push_back(e);
  endtask

  // One clock: sample after the edge, score any strobe, then model the datapath PC.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (core_reset === 1'b1) pc = 32'd0;
    if (core_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 32'(core_en), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
        chk("strobe_pc", pc, e.pc);
      end
      pc = pc + 32'd4;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
    for (int i = 0; i < budget && state !== s; i++) tick();
    chk(tag, 32'(state), 32'(s));
  endtask

  initial begin
    int c;
    int n;
    reset = 1'b1; step_btn = 1'b0; run_sw = 1'b0;
    pc = 32'd0; bp_addr = 32'd8; bp_valid = 1'b0;

    // Reset and init pulse
    ticks(2);
    reset = 1'b0;
    chk("rst_state", 32'(state), 32'(ST_INIT));
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_core_en", 32'(core_en), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_bp_hit", 32'(bp_hit), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    n = 0;
    for (int i = 0; i < 20 && core_reset === 1'b1; i++) begin
      n++;
      tick();
    end
    chk("core_reset_len", 32'(n), 32'd4);
    chk("init_to_idle", 32'(state), 32'(ST_IDLE));

    // Long step press: one strobe 3 edges after first sample
    c = cyc; step_btn = 1'b1; push(c + 4, 32'd0);
    ticks(10);
    step_btn = 1'b0;
    ticks(5);
    chk("step_long_pending", 32'(exp_q.size()), 32'd0);
    chk("step_long_count", 32'(instr_count), 32'd1);

    // Single-cycle press
    c = cyc; step_btn = 1'b1; push(c + 4, 32'd4);
    tick();
    step_btn = 1'b0;
    ticks(6);
    chk("step_short_count", 32'(instr_count), 32'd2);

    // Free run: strobes every RUN_DIV after RUN entry, stop on switch low
    c = cyc; run_sw = 1'b1;
    push(c + 9, 32'd8); push(c + 14, 32'd12); push(c + 19, 32'd16);
    ticks(4);
    chk("run_entered", 32'(state), 32'(ST_RUN));
    ticks(15);
    run_sw = 1'b0;
    ticks(25);
    chk("run_pending", 32'(exp_q.size()), 32'd0);
    chk("run_stop_state", 32'(state), 32'(ST_IDLE));
    chk("run_count", 32'(instr_count), 32'd5);

    // Step and run edges together: run wins, no immediate strobe
    c = cyc; run_sw = 1'b1; step_btn = 1'b1; push(c + 9, 32'd20);
    ticks(4);
    chk("coinc_state", 32'(state), 32'(ST_RUN));
    chk("coinc_no_strobe", 32'(instr_count), 32'd5);
    step_btn = 1'b0;
    ticks(5);
    run_sw = 1'b0;
    ticks(10);
    chk("coinc_pending", 32'(exp_q.size()), 32'd0);
    chk("coinc_count", 32'(instr_count), 32'd6);

    // End of program in RUN
    c = cyc; run_sw = 1'b1; push(c + 9, 32'd24);
    ticks(11);
    pc = 32'd128;
    ticks(2);
    chk("halt_state", 32'(state), 32'(ST_HALT));
    chk("halt_flag", 32'(halted), 32'd1);
    ticks(10);
    chk("halt_pending", 32'(exp_q.size()), 32'd0);
    chk("halt_count", 32'(instr_count), 32'd7);
    step_btn = 1'b1;
    ticks(6);
    step_btn = 1'b0;
    ticks(2);
    chk("halt_step_run_high", 32'(state), 32'(ST_HALT));
    run_sw = 1'b0;
    ticks(5);
    step_btn = 1'b1;
    ticks(4);
    step_btn = 1'b0;
    chk("reinit_state", 32'(state), 32'(ST_INIT));
    chk("reinit_core_reset", 32'(core_reset), 32'd1);
    chk("reinit_count", 32'(instr_count), 32'd0);
    wait_state(ST_IDLE, 12, "reinit_to_idle");
    chk("reinit_halted", 32'(halted), 32'd0);

    // Breakpoint at byte address 8, running from pc 0
    bp_addr = 32'd8; bp_valid = 1'b1;
    c = cyc; run_sw = 1'b1;
    push(c + 9, 32'd0); push(c + 14, 32'd4);
`ifdef EXEC_BREAKPOINT_EN
    ticks(19);
    chk("bp_stop_state", 32'(state), 32'(ST_IDLE));
    chk("bp_hit_set", 32'(bp_hit), 32'd1);
    ticks(5);
    chk("bp_run_held_idle", 32'(state), 32'(ST_IDLE));
    chk("bp_pending", 32'(exp_q.size()), 32'd0);
    run_sw = 1'b0;
    ticks(5);
    c = cyc; run_sw = 1'b1; push(c + 9, 32'd8);
    ticks(4);
    chk("bp_resume_state", 32'(state), 32'(ST_RUN));
    chk("bp_hit_cleared", 32'(bp_hit), 32'd0);
    ticks(5);
    run_sw = 1'b0;
    ticks(10);
    chk("bp_resume_pending", 32'(exp_q.size()), 32'd0);
    chk("bp_count", 32'(instr_count), 32'd3);
    chk("bp_hit_after_switch", 32'(bp_hit), 32'd0);
`else
    push(c + 19, 32'd8);
    ticks(19);
    run_sw = 1'b0;
    ticks(10);
    chk("nobp_pending", 32'(exp_q.size()), 32'd0);
    chk("nobp_state", 32'(state), 32'(ST_IDLE));
    chk("nobp_hit", 32'(bp_hit), 32'd0);
    chk("nobp_count", 32'(instr_count), 32'd3);
`endif

    // Reset in the middle of a run drops the pending divider count
    bp_valid = 1'b0;
    run_sw = 1'b1;
    ticks(6);
    chk("midrun_state", 32'(state), 32'(ST_RUN));
    reset = 1'b1;
    tick();
    chk("midrun_rst_state", 32'(state), 32'(ST_INIT));
    chk("midrun_rst_core_en", 32'(core_en), 32'd0);
    chk("midrun_rst_count", 32'(instr_count), 32'd0);
    reset = 1'b0; run_sw = 1'b0;
    wait_state(ST_IDLE, 20, "midrun_to_idle");
    ticks(15);
    chk("midrun_pending", 32'(exp_q.size()), 32'd0);
    chk("midrun_final_count", 32'(instr_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exec_step_controller.md
# exec_step_controller

Execution sequencer that sits between the FPGA board inputs and the single-cycle RISC-V datapath. It drives a one-cycle `core_en` strobe, which gates PC, register-file and data-memory updates, so the core advances exactly one instruction per strobe. It supports single-step from a push-button, free-run at a programmable rate, and end-of-program halt. It also issues the initialisation pulse that loads instruction/data memory and clears the registers.

## Interface
- `RUN_DIV`, default 25_000_000: clock cycles between strobes in run mode; must be ≥ 2.
- `MAX_PC`, default 124: last valid instruction byte address.
- `RST_CYCLES`, default 4: length of the `core_reset` pulse after `reset`, in cycles; must be ≥ 1.
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high.
- `step_btn`  in  1  raw push-button, active-high, asynchronous to `clk`.
- `run_sw`  in  1  raw slide switch, active-high: run mode request.
- `pc`  in  32  current datapath PC.
- `bp_addr`  in  32  breakpoint byte address.
- `bp_valid`  in  1  breakpoint armed.
- `core_en`  out  1  one-cycle advance strobe to the datapath.
- `core_reset`  out  1  datapath reset/memory-init.
- `state`  out  2  FSM state for display/LEDs.
- `halted`  out  1  end of program reached.
- `bp_hit`  out  1  sticky flag: last stop was a breakpoint.
- `instr_count`  out  16  strobes issued since init, saturating.

## Operation
- Inputs: `step_btn` and `run_sw` each pass through a 2-flop synchroniser and a rising-edge detector. Only synchronised values are used.
- States: INIT=0, IDLE=1, RUN=2, HALT=3.
- INIT (entered on `reset`)
  - `core_reset`=1 for RST_CYCLES cycles; cycle counter cleared on entry.
  - Then → IDLE with `core_reset`=0.
  - `instr_count` and `bp_hit` cleared.
- IDLE
  - Step edge → one `core_en` pulse; stay in IDLE.
  - `run_sw` rising edge → RUN: divider cleared, `bp_skip` set, `bp_hit` cleared.
  - Run edge and step edge in the same cycle: run wins and no step pulse is issued.
  - `run_sw` held high without an edge does not enter RUN.
- RUN
  - Divider counts 0..RUN_DIV-1. At RUN_DIV-1 it issues `core_en` and wraps to 0.
  - Step edges are ignored.
  - Synchronised `run_sw`=0 → IDLE; the divider is abandoned and no pulse is issued.
  - Breakpoint: the check happens at terminal count before issuing the strobe. If `bp_valid` and `pc`==`bp_addr` and not `bp_skip` → IDLE, no strobe, `bp_hit`=1.
  - `bp_skip` clears after the first strobe in RUN, so resuming from a breakpoint executes that instruction.
- End of program: in IDLE or RUN, while `core_en`=0, `pc` > MAX_PC → HALT. This takes priority over step, run and breakpoint.
- HALT
  - `halted`=1, no strobes.
  - Step edge with `run_sw`=0 → INIT, which re-initialises the core.
  - Otherwise stays in HALT.
- `instr_count` increments on every `core_en` and saturates at 16'hFFFF.

## Timing
- Values at `reset` (synchronous, active-high) and on the cycle after: `state`=INIT, `core_reset`=1, `core_en`=0, `halted`=0, `bp_hit`=0, `instr_count`=0.
- Reset mid-RUN: the next cycle is INIT, `core_en`=0, and any pending divider count is lost.
- All outputs are registered.
- Step latency: `core_en` goes high 3 edges after the first edge that samples `step_btn` high. It is exactly 1 cycle wide per press, regardless of hold time.
- Run mode: first strobe is RUN_DIV cycles after the RUN entry edge; strobes then repeat every RUN_DIV cycles.
- `pc` is sampled only in cycles where `core_en`=0. The datapath updates PC on the strobe edge, so `pc` is stable by the next check.
- RUN → IDLE on `run_sw` low: 2-cycle synchroniser latency. At most one strobe can issue in that window.

## Configuration
- `EXEC_BREAKPOINT_EN` defined:
  - breakpoint logic, `bp_skip` and `bp_hit` are built as described above.
- Undefined:
  - `bp_addr` and `bp_valid` ports remain but are ignored.
  - `bp_hit` is tied to 0.
  - RUN stops only on `run_sw` low or end of program.

## Structure
- Package `exec_ctrl_pkg`:
  - state encoding constants (INIT, IDLE, RUN, HALT);
  - count width 16 and saturation value 16'hFFFF.
- Sub-module `btn_edge_sync`:
  - 2-flop synchroniser plus rising-edge detector;
  - outputs level and edge;
  - instantiated for `step_btn` and `run_sw`.
- Divider, INIT counter and FSM live in the top module.

## Test plan
- Reset held 2 cycles, RST_CYCLES=4 → `core_reset` high for 4 cycles after release, `state` INIT→IDLE, all other outputs 0.
- `step_btn` held 10 cycles in IDLE, `pc`=0 → exactly one `core_en` 3 edges after first sample, `instr_count`=1.
- RUN_DIV=5, `run_sw` rises, `pc`<MAX_PC → strobes at cycles 5, 10, 15 after RUN entry. `run_sw` low → no strobe later than 2 cycles after the fall.
- `EXEC_BREAKPOINT_EN`, `bp_addr`=8, `bp_valid`=1, RUN from `pc`=0 → 2 strobes, then IDLE with `bp_hit`=1. Re-raising `run_sw` → next strobe executes pc=8.
- `pc` forced to 128 with MAX_PC=124 in RUN → HALT, `halted`=1, no further strobes. Step edge with `run_sw`=0 → INIT, `instr_count`=0.
- Step edge coincident with `run_sw` rising edge in IDLE → RUN entered, no immediate strobe.
